// File: rtl/axi4_master_burst_engine.sv
// rtl/axi4_master_burst_engine.sv - AXI4 INCR burst master, one burst per command; AXI4_MASTER_BURST_WAIT_EN adds LFSR wait insertion
module axi4_master_burst_engine #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          ID_WIDTH   = 1,
    parameter int          MAX_LEN    = 15,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic [ID_WIDTH-1:0]       cmd_id,
    output logic                      cmd_done,
    output logic [1:0]                cmd_resp,
    output logic                      cmd_err,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      rd_last,
    input  logic                      rd_ready,
    output logic [ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                M_AXI_AWLEN,
    output logic [2:0]                M_AXI_AWSIZE,
    output logic [1:0]                M_AXI_AWBURST,
    output logic                      M_AXI_AWLOCK,
    output logic [3:0]                M_AXI_AWCACHE,
    output logic [2:0]                M_AXI_AWPROT,
    output logic [3:0]                M_AXI_AWQOS,
    output logic [3:0]                M_AXI_AWREGION,
    output logic                      M_AXI_AWUSER,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WLAST,
    output logic                      M_AXI_WUSER,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ID_WIDTH-1:0]       M_AXI_ARID,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                M_AXI_ARLEN,
    output logic [2:0]                M_AXI_ARSIZE,
    output logic [1:0]                M_AXI_ARBURST,
    output logic                      M_AXI_ARLOCK,
    output logic [3:0]                M_AXI_ARCACHE,
    output logic [2:0]                M_AXI_ARPROT,
    output logic [3:0]                M_AXI_ARQOS,
    output logic [3:0]                M_AXI_ARREGION,
    output logic                      M_AXI_ARUSER,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [ID_WIDTH-1:0]       M_AXI_RID,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RLAST,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR      = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_ADDR = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam int         BYTES     = DATA_WIDTH / 8;
    localparam logic [2:0] SIZE      = (DATA_WIDTH == 128) ? 3'd4 : (DATA_WIDTH == 64) ? 3'd3 : 3'd2;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  awvalid_q;
    logic                  arvalid_q;
    logic                  aw_done;
    logic                  w_done;
    logic [7:0]            wr_cnt;
    logic [7:0]            rd_cnt;
    logic [1:0]            resp_q;
    logic                  err_q;

    logic                  cmd_fire;
    logic                  reject;
    logic [13:0]           burst_end;
    logic                  gate_open;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  wlast_fire;
    logic                  r_fire;
    logic [1:0]            worst_resp;

    // A burst of BYTES*(len+1) must end at or before the next 4 KB page.
    always_comb begin
        burst_end = {2'b00, cmd_addr[11:0]} + ((14'(cmd_len) + 14'd1) << SIZE);
        reject    = (cmd_len > MAX_LEN_B) ||
                    (|(cmd_addr & ADDR_WIDTH'(BYTES - 1))) ||
                    (burst_end > 14'd4096);
    end

    assign cmd_ready  = (state == IDLE) && !rst;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign cmd_done   = (state == DONE);
    assign cmd_err    = (state == DONE) && err_q;
    assign cmd_resp   = resp_q;

    assign M_AXI_WVALID = (state == WR) && !w_done && wr_valid && gate_open;
    assign M_AXI_WDATA  = (state == WR) ? wr_data : '0;
    assign M_AXI_WSTRB  = (state == WR) ? '1 : '0;
    assign M_AXI_WLAST  = (state == WR) && (wr_cnt == len_q);
    assign M_AXI_WUSER  = 1'b0;
    assign wr_ready     = M_AXI_WREADY && M_AXI_WVALID;
    assign w_fire       = M_AXI_WVALID && M_AXI_WREADY;
    assign wlast_fire   = w_fire && M_AXI_WLAST;
    assign aw_fire      = awvalid_q && M_AXI_AWREADY;
    assign M_AXI_BREADY = (state == WR_RESP);

    assign M_AXI_RREADY = (state == RD_DATA) && rd_ready && gate_open;
    assign rd_valid     = (state == RD_DATA) && M_AXI_RVALID;
    assign rd_data      = (state == RD_DATA) ? M_AXI_RDATA : '0;
    assign rd_last      = (state == RD_DATA) && (rd_cnt == len_q);
    assign r_fire       = M_AXI_RVALID && M_AXI_RREADY;
    assign worst_resp   = (M_AXI_RRESP > resp_q) ? M_AXI_RRESP : resp_q;

    assign M_AXI_AWID     = id_q;
    assign M_AXI_AWADDR   = addr_q;
    assign M_AXI_AWLEN    = len_q;
    assign M_AXI_AWSIZE   = SIZE;
    assign M_AXI_AWBURST  = 2'b01;
    assign M_AXI_AWLOCK   = 1'b0;
    assign M_AXI_AWCACHE  = 4'b0011;
    assign M_AXI_AWPROT   = 3'b000;
    assign M_AXI_AWQOS    = 4'd0;
    assign M_AXI_AWREGION = 4'd0;
    assign M_AXI_AWUSER   = 1'b0;
    assign M_AXI_AWVALID  = awvalid_q;
    assign M_AXI_ARID     = id_q;
    assign M_AXI_ARADDR   = addr_q;
    assign M_AXI_ARLEN    = len_q;
    assign M_AXI_ARSIZE   = SIZE;
    assign M_AXI_ARBURST  = 2'b01;
    assign M_AXI_ARLOCK   = 1'b0;
    assign M_AXI_ARCACHE  = 4'b0011;
    assign M_AXI_ARPROT   = 3'b000;
    assign M_AXI_ARQOS    = 4'd0;
    assign M_AXI_ARREGION = 4'd0;
    assign M_AXI_ARUSER   = 1'b0;
    assign M_AXI_ARVALID  = arvalid_q;

    logic unused_ids;
    assign unused_ids = ^{M_AXI_BID, M_AXI_RID};

`ifdef AXI4_MASTER_BURST_WAIT_EN
    logic [15:0] lfsr;
    logic [1:0]  wait_q;

    // Wait count is reloaded only when a beat completes, so an asserted VALID is never pulled back.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr   <= LFSR_SEED;
            wait_q <= 2'd0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if ((cmd_fire && !reject) || (w_fire && !M_AXI_WLAST) || (r_fire && !M_AXI_RLAST))
                wait_q <= lfsr[1:0];
            else if (wait_q != 2'd0)
                wait_q <= wait_q - 2'd1;
        end
    end
    assign gate_open = (wait_q == 2'd0);
`else
    logic [15:0] unused_seed;
    assign unused_seed = LFSR_SEED;
    assign gate_open   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            len_q     <= 8'd0;
            id_q      <= '0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            wr_cnt    <= 8'd0;
            rd_cnt    <= 8'd0;
            resp_q    <= 2'b00;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        addr_q  <= cmd_addr;
                        len_q   <= cmd_len;
                        id_q    <= cmd_id;
                        wr_cnt  <= 8'd0;
                        rd_cnt  <= 8'd0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (reject) begin
                            resp_q <= 2'b10;
                            err_q  <= 1'b1;
                            state  <= DONE;
                        end else begin
                            resp_q <= 2'b00;
                            err_q  <= 1'b0;
                            if (cmd_write) begin
                                awvalid_q <= 1'b1;
                                state     <= WR;
                            end else begin
                                arvalid_q <= 1'b1;
                                state     <= RD_ADDR;
                            end
                        end
                    end
                end
                WR: begin
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_fire)
                        wr_cnt <= M_AXI_WLAST ? 8'd0 : wr_cnt + 8'd1;
                    if (wlast_fire)
                        w_done <= 1'b1;
                    if ((aw_done || aw_fire) && (w_done || wlast_fire))
                        state <= WR_RESP;
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        resp_q <= M_AXI_BRESP;
                        state  <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_fire) begin
                        resp_q <= worst_resp;
                        rd_cnt <= rd_last ? 8'd0 : rd_cnt + 8'd1;
                        if (M_AXI_RLAST != rd_last)
                            err_q <= 1'b1;
                        if (M_AXI_RLAST)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_master_burst_engine.sv
// tb/tb_axi4_master_burst_engine.sv - scoreboard bench for axi4_master_burst_engine with a behavioural AXI4 slave
module tb_axi4_master_burst_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_write, cmd_done, cmd_err;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [0:0]  cmd_id;
    logic [1:0]  cmd_resp;
    logic [31:0] wr_data, rd_data;
    logic        wr_valid, wr_ready, rd_valid, rd_last, rd_ready;
    logic [0:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awlock, arlock, awuser, aruser, wuser;
    logic [3:0]  awcache, arcache, awqos, arqos, awregion, arregion, wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    axi4_master_burst_engine dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_id(cmd_id), .cmd_done(cmd_done), .cmd_resp(cmd_resp), .cmd_err(cmd_err),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot),
        .M_AXI_AWQOS(awqos), .M_AXI_AWREGION(awregion), .M_AXI_AWUSER(awuser),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WUSER(wuser),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
        .M_AXI_ARQOS(arqos), .M_AXI_ARREGION(arregion), .M_AXI_ARUSER(aruser),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    typedef struct packed { logic [31:0] data; logic last; } beat_t;
    typedef struct packed { logic [31:0] addr; logic [7:0] len; } addr_t;
    typedef struct packed { logic [1:0] resp; logic err; logic no_axi; } cmd_t;

    beat_t       exp_w[$], exp_r[$];
    addr_t       exp_aw[$], exp_ar[$];
    cmd_t        exp_cmd[$];
    logic [31:0] wr_src[$];

    int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
    int acc_cyc = 0, end_cyc = 0;
    logic hs_cmd = 0, hs_aw = 0, hs_w = 0, hs_wlast = 0, hs_b = 0, hs_ar = 0, hs_r = 0, hs_rlast = 0;
    logic axi_seen = 0, aw_seen = 0, wlast_seen = 0, bready_chk = 0, first_aw = 0, first_ar = 0;
    logic prev_awv = 0;
    logic [31:0] prev_awaddr = 0;
    logic [7:0]  prev_awlen = 0;

    int          aw_hold = 0, r_beat = 0, r_last_at = 0, r_err_beat = -1;
    logic [31:0] r_base = 0;
    logic [1:0]  s_bresp = 2'b00;
    logic        s_aw_got = 0, s_w_got = 0, r_active = 0, rd_bp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            {hs_cmd, hs_aw, hs_w, hs_wlast, hs_b, hs_ar, hs_r, hs_rlast} = '0;
            prev_awv = 1'b0;
        end else begin
            hs_cmd   = cmd_valid & cmd_ready;
            hs_aw    = awvalid & awready;
            hs_w     = wvalid & wready;
            hs_wlast = hs_w & wlast;
            hs_b     = bvalid & bready;
            hs_ar    = arvalid & arready;
            hs_r     = rvalid & rready;
            hs_rlast = hs_r & rlast;
            if (awvalid | arvalid | wvalid) axi_seen = 1'b1;
            if (cmd_done) begin
                done_cnt++;
                if (exp_cmd.size() == 0) begin
                    check("unexpected cmd_done", 64'(1), 64'(0));
                end else begin
                    cmd_t e;
                    e = exp_cmd.pop_front();
                    check("cmd_resp", 64'(cmd_resp), 64'(e.resp));
                    check("cmd_err", 64'(cmd_err), 64'(e.err));
                    if (e.no_axi) check("rejected cmd axi activity", 64'(axi_seen), 64'(0));
                    else          check("cmd_done latency", 64'(cyc - end_cyc), 64'(1));
                end
            end
            if (prev_awv)
                check("aw held stable", 64'({awvalid, awaddr, awlen}), 64'({1'b1, prev_awaddr, prev_awlen}));
            prev_awv = awvalid & ~awready;
            prev_awaddr = awaddr;
            prev_awlen = awlen;
            if (awvalid && first_aw) begin
                check("awvalid latency", 64'(cyc - acc_cyc), 64'(1));
                first_aw = 1'b0;
            end
            if (hs_aw) begin
                aw_seen = 1'b1;
                if (exp_aw.size() == 0) check("unexpected aw", 64'(1), 64'(0));
                else begin
                    addr_t a;
                    a = exp_aw.pop_front();
                    check("aw addr/len", 64'({awaddr, awlen}), 64'({a.addr, a.len}));
                    check("aw size/burst/cache", 64'({awsize, awburst, awcache}), 64'({3'd2, 2'b01, 4'b0011}));
                end
            end
            if (hs_w) begin
                if (exp_w.size() == 0) check("unexpected w beat", 64'(1), 64'(0));
                else begin
                    beat_t b;
                    b = exp_w.pop_front();
                    check("w data/last/strb", 64'({wdata, wlast, wstrb}), 64'({b.data, b.last, 4'hF}));
                end
                if (wlast) wlast_seen = 1'b1;
            end
            if (bready && !bready_chk) begin
                check("bready after aw and wlast", 64'(aw_seen & wlast_seen), 64'(1));
                bready_chk = 1'b1;
            end
            if (hs_b) end_cyc = cyc;
            if (arvalid && first_ar) begin
                check("arvalid latency", 64'(cyc - acc_cyc), 64'(1));
                first_ar = 1'b0;
            end
            if (hs_ar) begin
                if (exp_ar.size() == 0) check("unexpected ar", 64'(1), 64'(0));
                else begin
                    addr_t a;
                    a = exp_ar.pop_front();
                    check("ar addr/len", 64'({araddr, arlen}), 64'({a.addr, a.len}));
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_r.size() == 0) check("unexpected rd beat", 64'(1), 64'(0));
                else begin
                    beat_t b;
                    b = exp_r.pop_front();
                    check("rd data/last", 64'({rd_data, rd_last}), 64'({b.data, b.last}));
                end
            end
            if (hs_rlast) end_cyc = cyc;
            if (hs_cmd) begin
                acc_cyc = cyc;
                {axi_seen, aw_seen, wlast_seen, bready_chk} = '0;
                first_aw = 1'b1;
                first_ar = 1'b1;
            end
        end
    end

    // Slave model and stream endpoints, driven just after each rising edge.
    always begin
        logic        rst_edge;
        logic [31:0] tmp;
        @(posedge clk);
        rst_edge = rst;
        #1;
        if (rst_edge) begin
            {s_aw_got, s_w_got, r_active, bvalid, rvalid, rlast} = '0;
            r_beat = 0;
        end else begin
            if (hs_w && wr_src.size() > 0) tmp = wr_src.pop_front();
            if (hs_aw) s_aw_got = 1'b1;
            if (hs_wlast) s_w_got = 1'b1;
            if (hs_b) begin
                bvalid = 1'b0;
                s_aw_got = 1'b0;
                s_w_got = 1'b0;
            end else if (s_aw_got && s_w_got) begin
                bvalid = 1'b1;
                bresp = s_bresp;
            end
            if (hs_ar) begin
                r_active = 1'b1;
                r_beat = 0;
            end
            if (hs_r) begin
                if (rlast) r_active = 1'b0;
                r_beat++;
            end
        end
        wr_valid = wr_src.size() > 0;
        wr_data = wr_valid ? wr_src[0] : 32'd0;
        awready = (aw_hold == 0);
        if (awvalid && aw_hold > 0) aw_hold--;
        rvalid = r_active;
        rdata = r_base + 32'(r_beat);
        rresp = (r_beat == r_err_beat) ? 2'b10 : 2'b00;
        rlast = r_active && (r_beat == r_last_at);
        rd_ready = rd_bp ? cyc[0] : 1'b1;
    end

    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = 1'b1; cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
        end
        if (!ok) check("cmd accept timeout", 64'(1), 64'(0));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (exp_cmd.size() == 0 && exp_w.size() == 0 && exp_r.size() == 0 &&
                exp_aw.size() == 0 && exp_ar.size() == 0) ok = 1;
        end
        if (!ok) check(name, 64'(1), 64'(0));
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        {cmd_valid, cmd_write, wr_valid, rd_ready, awready, wready, bvalid, arready, rvalid, rlast} = '0;
        cmd_addr = 0; cmd_len = 0; cmd_id = 0; wr_data = 0;
        bid = 0; rid = 0; bresp = 0; rresp = 0; rdata = 0;
        wready = 1'b1; arready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("cmd_ready in reset", 64'(cmd_ready), 64'(0));
        check("outputs in reset", 64'({awvalid, wvalid, bready, arvalid, rready, rd_valid, cmd_done, cmd_err, cmd_resp, awaddr}), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("cmd_ready after reset", 64'(cmd_ready), 64'(1));

        // Write 0x1000 len 3
        for (int i = 0; i < 4; i++) begin
            wr_src.push_back(32'hA0 + 32'(i));
            exp_w.push_back('{32'hA0 + 32'(i), i == 3});
        end
        exp_aw.push_back('{32'h1000, 8'd3});
        exp_cmd.push_back('{2'b00, 1'b0, 1'b0});
        do_cmd(1'b1, 32'h1000, 8'd3);
        wait_idle("write len3 timeout");

        // Read 0x2000 len 7, SLVERR on beat 5, reader backpressure
        r_base = 32'hB0; r_last_at = 7; r_err_beat = 5; rd_bp = 1'b1;
        for (int i = 0; i < 8; i++) exp_r.push_back('{32'hB0 + 32'(i), i == 7});
        exp_ar.push_back('{32'h2000, 8'd7});
        exp_cmd.push_back('{2'b10, 1'b0, 1'b0});
        do_cmd(1'b0, 32'h2000, 8'd7);
        wait_idle("read len7 timeout");
        rd_bp = 1'b0; r_err_beat = -1;

        // AWREADY withheld 5 cycles while W finishes first
        aw_hold = 5;
        wr_src.push_back(32'h11); wr_src.push_back(32'h12);
        exp_w.push_back('{32'h11, 1'b0}); exp_w.push_back('{32'h12, 1'b1});
        exp_aw.push_back('{32'h3000, 8'd1});
        exp_cmd.push_back('{2'b00, 1'b0, 1'b0});
        do_cmd(1'b1, 32'h3000, 8'd1);
        wait_idle("aw hold timeout");

        // Rejections: 4 KB crossing, length above MAX_LEN, misaligned address
        exp_cmd.push_back('{2'b10, 1'b1, 1'b1});
        do_cmd(1'b1, 32'h0FF8, 8'd3);
        wait_idle("reject 4k timeout");
        exp_cmd.push_back('{2'b10, 1'b1, 1'b1});
        do_cmd(1'b0, 32'h4000, 8'd16);
        wait_idle("reject len timeout");
        exp_cmd.push_back('{2'b10, 1'b1, 1'b1});
        do_cmd(1'b1, 32'h4002, 8'd0);
        wait_idle("reject align timeout");

        // Read len 3 with RLAST early on beat 1
        r_base = 32'hC0; r_last_at = 1;
        exp_r.push_back('{32'hC0, 1'b0}); exp_r.push_back('{32'hC1, 1'b0});
        exp_ar.push_back('{32'h5000, 8'd3});
        exp_cmd.push_back('{2'b00, 1'b1, 1'b0});
        do_cmd(1'b0, 32'h5000, 8'd3);
        wait_idle("rlast early timeout");

        // Single-beat write, EXOKAY response passed through
        s_bresp = 2'b01;
        wr_src.push_back(32'h77);
        exp_w.push_back('{32'h77, 1'b1});
        exp_aw.push_back('{32'h6000, 8'd0});
        exp_cmd.push_back('{2'b01, 1'b0, 1'b0});
        do_cmd(1'b1, 32'h6000, 8'd0);
        wait_idle("write len0 timeout");
        s_bresp = 2'b00;

        // Reset after beat 1 of a 4-beat write: abandoned, no cmd_done
        wr_src.push_back(32'hE0); wr_src.push_back(32'hE1);
        exp_w.push_back('{32'hE0, 1'b0}); exp_w.push_back('{32'hE1, 1'b0});
        exp_aw.push_back('{32'h7000, 8'd3});
        do_cmd(1'b1, 32'h7000, 8'd3);
        wait_idle("partial write timeout");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("outputs after mid-burst reset", 64'({awvalid, wvalid, wlast, bready, arvalid, rready, rd_valid, cmd_done, cmd_err, cmd_resp, awaddr}), 64'(0));
        check("cmd_ready after mid-burst reset", 64'(cmd_ready), 64'(1));
        repeat (3) @(posedge clk);

        // Read after reset completes normally
        r_base = 32'hD0; r_last_at = 1;
        exp_r.push_back('{32'hD0, 1'b0}); exp_r.push_back('{32'hD1, 1'b1});
        exp_ar.push_back('{32'h2100, 8'd1});
        exp_cmd.push_back('{2'b00, 1'b0, 1'b0});
        do_cmd(1'b0, 32'h2100, 8'd1);
        wait_idle("read after reset timeout");

        check("cmd_done pulse count", 64'(done_cnt), 64'(9));
        check("leftover expectations", 64'(exp_cmd.size() + exp_w.size() + exp_r.size() + exp_aw.size() + exp_ar.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
